mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single data port of the unified memory between two requesters: the core
//  load/store path (port C) and the program loader/debug path (port L).
//  Round-robin arbitration, valid/ready request handshake, one-cycle response pulse.
//  Converts RISC-V funct3 sizes into byte write masks, lane-replicated write data and
//  sign/zero-extended load data; flags misaligned, illegal or out-of-range accesses.
// PARAMETERS
//  MEM_BYTES  4096  byte size of backing memory; byte addresses >= MEM_BYTES are errors
// PORTS
//  i_clk            in   1   clock, all state updates on rising edge
//  i_rst            in   1   asynchronous, active-high reset
//  i_c_valid        in   1   core request valid
//  o_c_ready        out  1   core request accepted this cycle (valid & ready)
//  i_c_write        in   1   1 = store, 0 = load
//  i_c_funct3       in   3   access size/sign (RV32I load/store funct3)
//  i_c_address      in   32  byte address (t_address)
//  i_c_wdata        in   32  store data, value in low bits (t_data)
//  o_c_rsp_valid    out  1   one-cycle pulse: core response valid
//  i_l_valid        in   1   loader request valid
//  o_l_ready        out  1   loader request accepted this cycle
//  i_l_write        in   1   1 = store, 0 = load; loader is always a full word
//  i_l_address      in   32  byte address
//  i_l_wdata        in   32  store data
//  o_l_rsp_valid    out  1   one-cycle pulse: loader response valid
//  o_rsp_data       out  32  load result (extended); 0 for stores and errors
//  o_rsp_error      out  1   access rejected (qualified by a rsp_valid)
//  o_mem_address    out  32  to memory data address
//  o_mem_wdata      out  32  to memory write data
//  o_mem_write_mask out  4   to memory byte mask, bit 0 = byte at addr[1:0]==0
//  o_mem_write_en   out  1   to memory write enable
//  i_mem_rdata      in   32  from memory data output (asynchronous read)
// BEHAVIOUR
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; one request per 3 cycles, no pipelining.
//  - IDLE: ready asserted combinationally to the winner only. Sole valid wins; both valid
//    -> port not granted last (r_last reset = L, so C wins first tie). Accept latches
//    port, write, size, address, wdata, error; state -> ACCESS.
//  - ACCESS (1 cycle): o_mem_address = latched address. Store without error: write_en=1,
//    mask SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0], SW 4'b1111; wdata byte x4 / half x2 /
//    word. Load: lane selected from i_mem_rdata, sign-extend LB/LH, zero-extend LBU/LHU,
//    registered at edge. -> RESP.
//  - RESP (1 cycle): rsp_valid of latched port =1, o_rsp_data/o_rsp_error valid; no
//    backpressure, requester must accept. -> IDLE; both readies low in ACCESS/RESP.
//  - Error: funct3 011/110/111, store funct3 1xx, half with a[0]=1, word with a[1:0]!=0,
//    address >= MEM_BYTES. Error access never asserts write_en; rsp_data = 0.
//  - write_en and write_mask are 0 outside ACCESS; combinational from state, so reset
//    removes them immediately.
//  - Reset values: state IDLE, all rsp_valid 0, o_rsp_data 0, o_rsp_error 0, latched
//    address/wdata 0, r_last = L. Reset mid-ACCESS/RESP aborts: no write, no response.
//  - Request inputs may change freely while ready is low; only the accept cycle samples.
// TESTING
//  - Core SW 0xDEADBEEF @0x10, then LW @0x10 -> write_en 1 mask 1111; rsp_data 0xDEADBEEF
//    exactly 2 cycles after accept, error 0.
//  - Core SB 0x80 @0x13, LB @0x13 -> mask 1000, wdata 0x80808080; LB 0xFFFFFF80,
//    LBU 0x00000080.
//  - Core LH @0x11 and loader SW @0x1002 -> o_rsp_error 1, rsp_data 0, write_en never 1.
//  - C and L valid continuously -> grants C,L,C,L..; each rsp_valid on its own port only.
//  - Core SW accepted, i_rst pulsed in ACCESS before edge -> no write, no rsp, IDLE after.
//  - Loader SW 0x12345678 @0xFFC (MEM_BYTES=4096) -> accepted, LW readback 0x12345678.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing the unified memory data port between the core (C) and loader (L).
// Converts RV32I funct3 sizes into byte masks and lane-replicated data, and extends load results.
module mem_access_arbiter #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_c_valid,
    output logic        o_c_ready,
    input  logic        i_c_write,
    input  logic [2:0]  i_c_funct3,
    input  logic [31:0] i_c_address,
    input  logic [31:0] i_c_wdata,
    output logic        o_c_rsp_valid,
    input  logic        i_l_valid,
    output logic        o_l_ready,
    input  logic        i_l_write,
    input  logic [31:0] i_l_address,
    input  logic [31:0] i_l_wdata,
    output logic        o_l_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_error,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_write_mask,
    output logic        o_mem_write_en,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        port_q, port_d;   // 0 = core, 1 = loader
    logic        last_q, last_d;
    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        grant_c, grant_l;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    function automatic logic access_err(logic wr, logic [2:0] f3, logic [31:0] a);
        logic e;
        e = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        e = e || (wr && f3[2]);
        e = e || ((f3[1:0] == 2'b01) && a[0]);
        e = e || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        e = e || (a >= 32'(MEM_BYTES));
        return e;
    endfunction

    always_comb begin
        ld_byte = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = i_mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        last_d     = last_q;
        write_d    = write_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        grant_c    = 1'b0;
        grant_l    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Tie goes to the port that was not served last.
                grant_c = i_c_valid && (!i_l_valid || last_q);
                grant_l = i_l_valid && !grant_c;
                if (grant_c) begin
                    port_d  = 1'b0;
                    write_d = i_c_write;
                    f3_d    = i_c_funct3;
                    addr_d  = i_c_address;
                    wdata_d = i_c_wdata;
                    err_d   = access_err(i_c_write, i_c_funct3, i_c_address);
                end else if (grant_l) begin
                    port_d  = 1'b1;
                    write_d = i_l_write;
                    f3_d    = 3'b010;
                    addr_d  = i_l_address;
                    wdata_d = i_l_wdata;
                    err_d   = access_err(i_l_write, 3'b010, i_l_address);
                end
                if (grant_c || grant_l) begin
                    last_d  = grant_l;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rsp_data_d = (err_q || write_q) ? 32'd0 : ld_val;
                rsp_err_d  = err_q;
                state_d    = S_RESP;
            end
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            port_q     <= 1'b0;
            last_q     <= 1'b1;
            write_q    <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            last_q     <= last_d;
            write_q    <= write_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        o_c_ready      = grant_c;
        o_l_ready      = grant_l;
        o_c_rsp_valid  = (state_q == S_RESP) && !port_q;
        o_l_rsp_valid  = (state_q == S_RESP) && port_q;
        o_rsp_data     = rsp_data_q;
        o_rsp_error    = rsp_err_q;
        o_mem_address  = addr_q;
        o_mem_write_en = (state_q == S_ACCESS) && write_q && !err_q;
        case (f3_q[1:0])
            2'b00:   o_mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   o_mem_wdata = {2{wdata_q[15:0]}};
            default: o_mem_wdata = wdata_q;
        endcase
        o_mem_write_mask = 4'b0000;
        if (o_mem_write_en) begin
            case (f3_q[1:0])
                2'b00:   o_mem_write_mask = 4'b0001 << addr_q[1:0];
                2'b01:   o_mem_write_mask = 4'b0011 << addr_q[1:0];
                default: o_mem_write_mask = 4'b1111;
            endcase
        end
    end

endmodule
